// File: rtl/toy_bus_pkg.sv
// ToyBus request/ack payload types shared by the round-robin ordering node,
// its interface and its order FIFO.
package toy_bus_pkg;

    localparam int TOY_BUS_ADDR_W = 32;
    localparam int TOY_BUS_DATA_W = 32;
    localparam int TOY_BUS_STRB_W = 4;
    localparam int TOY_BUS_ID_W   = 4;
    localparam int NUM_PORTS      = 2;

    typedef struct packed {
        logic [TOY_BUS_ADDR_W-1:0] addr;
        logic [TOY_BUS_STRB_W-1:0] strb;
        logic [TOY_BUS_DATA_W-1:0] data;
        logic                      opcode;
        logic [TOY_BUS_ID_W-1:0]   src_id;
        logic [TOY_BUS_ID_W-1:0]   tgt_id;
    } toy_bus_req_t;

    typedef struct packed {
        logic                      opcode;
        logic [TOY_BUS_DATA_W-1:0] data;
        logic [TOY_BUS_ID_W-1:0]   src_id;
        logic [TOY_BUS_ID_W-1:0]   tgt_id;
    } toy_bus_ack_t;

endpackage

// File: rtl/toy_bus_rr_arb_ord_node_if.sv
// Bundle of both requester ports, the target port and status for the ordering node.
// Index N of each in_* vector is requester N.
interface toy_bus_rr_arb_ord_node_if #(
    parameter int CNT_W = 3
);
    import toy_bus_pkg::*;

    logic         [NUM_PORTS-1:0] in_req_vld;
    logic         [NUM_PORTS-1:0] in_req_rdy;
    toy_bus_req_t [NUM_PORTS-1:0] in_req;

    logic                         out0_req_vld;
    logic                         out0_req_rdy;
    toy_bus_req_t                 out0_req;

    logic                         out0_ack_vld;
    logic                         out0_ack_rdy;
    toy_bus_ack_t                 out0_ack;

    logic         [NUM_PORTS-1:0] in_ack_vld;
    logic         [NUM_PORTS-1:0] in_ack_rdy;
    toy_bus_ack_t [NUM_PORTS-1:0] in_ack;

    logic         [CNT_W-1:0]     ost_cnt;
    logic                         err_unexp_ack;

    modport master (
        output in_req_vld, in_req, out0_req_rdy, out0_ack_vld, out0_ack, in_ack_rdy,
        input  in_req_rdy, out0_req_vld, out0_req, out0_ack_rdy, in_ack_vld, in_ack,
        input  ost_cnt, err_unexp_ack
    );

    modport slave (
        input  in_req_vld, in_req, out0_req_rdy, out0_ack_vld, out0_ack, in_ack_rdy,
        output in_req_rdy, out0_req_vld, out0_req, out0_ack_rdy, in_ack_vld, in_ack,
        output ost_cnt, err_unexp_ack
    );

endinterface

// File: rtl/toy_bus_rr_arb_ord_node_fifo.sv
// In-order ID FIFO: remembers which requester owns each outstanding transaction.
// Caller guarantees no push when full and no pop when empty.
module toy_bus_ord_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_din,
    input  logic             i_pop,
    output logic             o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            // Occupancy tracked separately so full and empty stay distinguishable.
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/toy_bus_rr_arb_ord_node.sv
// Two-requester round-robin arbiter in front of one ToyBus target, with in-order
// ack routing back to the requester that owns the oldest outstanding transaction.
module toy_bus_rr_arb_ord_node
    import toy_bus_pkg::*;
#(
    parameter int OST_DEPTH = 4,
    parameter int CNT_W     = $clog2(OST_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    toy_bus_rr_arb_ord_node_if.slave     bus
);
    logic             w_full;
    logic             w_empty;
    logic             w_head;
    logic [CNT_W-1:0] w_cnt;
    logic             w_grant;
    logic             w_out_vld;
    logic             w_req_fire;
    logic             w_ack_fire;

    logic             r_rr_ptr;
    logic             r_lock;
    logic             r_lock_port;
    logic             r_err;

    // A stalled grant is pinned so a late-arriving second requester cannot steal it.
    always_comb begin
        w_grant = bus.in_req_vld[1];
        if (r_lock && bus.in_req_vld[r_lock_port]) begin
            w_grant = r_lock_port;
        end else if (&bus.in_req_vld) begin
            w_grant = r_rr_ptr;
        end
        w_out_vld  = (|bus.in_req_vld) & ~w_full & ~rst;
        w_req_fire = w_out_vld & bus.out0_req_rdy;
        w_ack_fire = bus.out0_ack_vld & ~w_empty & bus.in_ack_rdy[w_head] & ~rst;
    end

    always_comb begin
        bus.out0_req_vld        = w_out_vld;
        bus.out0_req            = bus.in_req[w_grant];
        bus.in_req_rdy          = '0;
        bus.in_req_rdy[w_grant] = bus.out0_req_rdy & ~w_full & ~rst;

        bus.in_ack_vld          = '0;
        bus.in_ack_vld[w_head]  = bus.out0_ack_vld & ~w_empty & ~rst;
        bus.in_ack              = {NUM_PORTS{bus.out0_ack}};
        // Acks with nothing outstanding are swallowed rather than allowed to hang the target.
        bus.out0_ack_rdy        = ~rst & (w_empty | bus.in_ack_rdy[w_head]);

        bus.ost_cnt             = w_cnt;
        bus.err_unexp_ack       = r_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= 1'b0;
            r_lock      <= 1'b0;
            r_lock_port <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_rr_ptr <= ~w_grant;
            end
            r_lock      <= w_out_vld & ~bus.out0_req_rdy;
            r_lock_port <= w_grant;
            if (bus.out0_ack_vld && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    toy_bus_ord_fifo #(
        .DEPTH (OST_DEPTH),
        .CNT_W (CNT_W)
    ) u_ord_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_req_fire),
        .i_din   (w_grant),
        .i_pop   (w_ack_fire),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

endmodule

// File: tb/tb_toy_bus_rr_arb_ord_node.sv
// Directed bench for the round-robin ordering node; stimulus pushes expected
// request grants and ack deliveries into queues that a negedge monitor drains.
module tb_toy_bus_rr_arb_ord_node;
    import toy_bus_pkg::*;

    typedef struct {
        int          port;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t exp_req_q[$];
    exp_t exp_ack_q[$];

    toy_bus_rr_arb_ord_node_if #(.CNT_W(3)) bus();

    toy_bus_rr_arb_ord_node #(
        .OST_DEPTH (4),
        .CNT_W     (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] src_of(input int p);
        return (p == 1) ? 4'hB : 4'hA;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic exp_req(input int p, input logic [31:0] a);
        exp_t e;
        e.port = p;
        e.val  = a;
        exp_req_q.push_back(e);
    endtask

    task automatic exp_ack(input int p, input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.val  = d;
        exp_ack_q.push_back(e);
        bus.out0_ack.data = d;
    endtask

    // Monitor: every fire seen on the target or a requester ack port consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.out0_req_vld && bus.out0_req_rdy) begin
                if (exp_req_q.size() == 0) begin
                    chk("req_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_req_q.pop_front();
                    chk("req_src", {28'd0, bus.out0_req.src_id}, {28'd0, src_of(e.port)});
                    chk("req_addr", bus.out0_req.addr, e.val);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (bus.in_ack_vld[p] && bus.in_ack_rdy[p]) begin
                    if (exp_ack_q.size() == 0) begin
                        chk("ack_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_ack_q.pop_front();
                        chk("ack_port", p, e.port);
                        chk("ack_data", bus.in_ack[p].data, e.val);
                    end
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.in_req_vld   = 2'b00;
        bus.in_req       = '0;
        bus.in_req[0].src_id = 4'hA;
        bus.in_req[1].src_id = 4'hB;
        bus.out0_req_rdy = 1'b1;
        bus.out0_ack_vld = 1'b0;
        bus.out0_ack     = '0;
        bus.in_ack_rdy   = 2'b11;

        // Reset: requests and acks presented but every handshake output held low.
        bus.in_req_vld   = 2'b11;
        bus.out0_ack_vld = 1'b1;
        at_neg();
        chk("rst_out_vld", {31'd0, bus.out0_req_vld}, 32'd0);
        chk("rst_in_rdy", {30'd0, bus.in_req_rdy}, 32'd0);
        chk("rst_ack_rdy", {31'd0, bus.out0_ack_rdy}, 32'd0);
        chk("rst_in_ack_vld", {30'd0, bus.in_ack_vld}, 32'd0);
        chk("rst_ost", {29'd0, bus.ost_cnt}, 32'd0);
        chk("rst_err", {31'd0, bus.err_unexp_ack}, 32'd0);
        tick();
        rst = 1'b0;
        bus.in_req_vld   = 2'b00;
        bus.out0_ack_vld = 1'b0;
        tick();

        // 1: port0 only, three back-to-back requests then three acks.
        for (int i = 0; i < 3; i++) begin
            bus.in_req_vld = 2'b01;
            bus.in_req[0].addr = 32'h100 + 32'(4 * i);
            exp_req(0, 32'h100 + 32'(4 * i));
            at_neg();
            chk("t1_ost", {29'd0, bus.ost_cnt}, 32'(i));
            tick();
        end
        bus.in_req_vld = 2'b00;
        at_neg();
        chk("t1_ost3", {29'd0, bus.ost_cnt}, 32'd3);
        tick();
        tick();
        bus.out0_ack_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_ack(0, 32'hD0 + 32'(i));
            at_neg();
            chk("t1_no_ack1", {31'd0, bus.in_ack_vld[1]}, 32'd0);
            tick();
        end
        bus.out0_ack_vld = 1'b0;
        at_neg();
        chk("t1_ost0", {29'd0, bus.ost_cnt}, 32'd0);
        tick();

        // 2: after reset, both ports always valid with prompt acks -> grants 0,1,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_req[0].addr = 32'h200;
        bus.in_req[1].addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            bus.in_req_vld = 2'b11;
            exp_req(i % 2, (i % 2 == 1) ? 32'h300 : 32'h200);
            if (i > 0) begin
                bus.out0_ack_vld = 1'b1;
                exp_ack((i - 1) % 2, 32'h20 + 32'(i - 1));
            end
            at_neg();
            chk("t2_ost", {29'd0, bus.ost_cnt}, (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        bus.in_req_vld = 2'b00;
        exp_ack(1, 32'h23);
        tick();
        bus.out0_ack_vld = 1'b0;
        at_neg();
        chk("t2_ost0", {29'd0, bus.ost_cnt}, 32'd0);
        tick();

        // 3: fill to OST_DEPTH with no acks, then one ack frees a slot a cycle later.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_req_vld = 2'b11;
        exp_req(0, 32'h200);
        exp_req(1, 32'h300);
        exp_req(0, 32'h200);
        exp_req(1, 32'h300);
        for (int i = 0; i < 6; i++) tick();
        at_neg();
        chk("t3_full_ost", {29'd0, bus.ost_cnt}, 32'd4);
        chk("t3_full_rdy", {30'd0, bus.in_req_rdy}, 32'd0);
        chk("t3_full_vld", {31'd0, bus.out0_req_vld}, 32'd0);
        tick();
        bus.out0_ack_vld = 1'b1;
        exp_ack(0, 32'hE0);
        at_neg();
        chk("t3_no_same_cyc", {31'd0, bus.out0_req_vld}, 32'd0);
        chk("t3_ack_rdy", {31'd0, bus.out0_ack_rdy}, 32'd1);
        tick();
        bus.out0_ack_vld = 1'b0;
        exp_req(0, 32'h200);
        at_neg();
        chk("t3_5th_rdy", {30'd0, bus.in_req_rdy}, 32'd1);
        chk("t3_ost3", {29'd0, bus.ost_cnt}, 32'd3);
        tick();
        bus.in_req_vld = 2'b00;
        at_neg();
        chk("t3_ost4", {29'd0, bus.ost_cnt}, 32'd4);
        tick();
        bus.out0_ack_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_ack((i % 2 == 0) ? 1 : 0, 32'hE1 + 32'(i));
            tick();
        end
        bus.out0_ack_vld = 1'b0;
        at_neg();
        chk("t3_ost0", {29'd0, bus.ost_cnt}, 32'd0);
        tick();

        // 4: port1 ack held off by its requester for five cycles.
        bus.in_req_vld = 2'b10;
        exp_req(1, 32'h300);
        tick();
        bus.in_req_vld   = 2'b00;
        bus.in_ack_rdy   = 2'b01;
        bus.out0_ack_vld = 1'b1;
        bus.out0_ack.data = 32'h40;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("t4_stall_rdy", {31'd0, bus.out0_ack_rdy}, 32'd0);
            chk("t4_stall_vld", {30'd0, bus.in_ack_vld}, 32'd2);
            chk("t4_stall_ost", {29'd0, bus.ost_cnt}, 32'd1);
            tick();
        end
        bus.in_ack_rdy = 2'b11;
        exp_ack(1, 32'h40);
        at_neg();
        chk("t4_release_rdy", {31'd0, bus.out0_ack_rdy}, 32'd1);
        tick();
        bus.out0_ack_vld = 1'b0;
        at_neg();
        chk("t4_ost0", {29'd0, bus.ost_cnt}, 32'd0);
        chk("t4_err0", {31'd0, bus.err_unexp_ack}, 32'd0);
        tick();

        // 5: ack with nothing outstanding is dropped and flagged stickily.
        bus.out0_ack_vld  = 1'b1;
        bus.out0_ack.data = 32'h50;
        at_neg();
        chk("t5_ack_rdy", {31'd0, bus.out0_ack_rdy}, 32'd1);
        chk("t5_no_ack_vld", {30'd0, bus.in_ack_vld}, 32'd0);
        tick();
        bus.out0_ack_vld = 1'b0;
        at_neg();
        chk("t5_err", {31'd0, bus.err_unexp_ack}, 32'd1);
        tick();
        tick();
        at_neg();
        chk("t5_err_sticky", {31'd0, bus.err_unexp_ack}, 32'd1);
        tick();

        // 6: reset with two outstanding, then a lone port1 request is granted at once.
        bus.in_req_vld = 2'b11;
        exp_req(0, 32'h200);
        exp_req(1, 32'h300);
        tick();
        tick();
        rst = 1'b1;
        bus.out0_ack_vld = 1'b1;
        at_neg();
        chk("t6_rst_vld", {31'd0, bus.out0_req_vld}, 32'd0);
        chk("t6_rst_rdy", {30'd0, bus.in_req_rdy}, 32'd0);
        chk("t6_rst_ack_rdy", {31'd0, bus.out0_ack_rdy}, 32'd0);
        chk("t6_rst_ack_vld", {30'd0, bus.in_ack_vld}, 32'd0);
        chk("t6_rst_ost", {29'd0, bus.ost_cnt}, 32'd0);
        chk("t6_rst_err", {31'd0, bus.err_unexp_ack}, 32'd0);
        tick();
        rst = 1'b0;
        bus.out0_ack_vld = 1'b0;
        bus.in_req_vld   = 2'b10;
        exp_req(1, 32'h300);
        at_neg();
        chk("t6_p1_rdy", {30'd0, bus.in_req_rdy}, 32'd2);
        tick();
        bus.in_req_vld = 2'b00;
        at_neg();
        chk("t6_ost1", {29'd0, bus.ost_cnt}, 32'd1);
        tick();
        bus.out0_ack_vld = 1'b1;
        exp_ack(1, 32'h60);
        tick();
        bus.out0_ack_vld = 1'b0;
        at_neg();
        chk("t6_ost0", {29'd0, bus.ost_cnt}, 32'd0);
        chk("t6_err0", {31'd0, bus.err_unexp_ack}, 32'd0);
        tick();

        chk("req_q_drained", 32'(exp_req_q.size()), 32'd0);
        chk("ack_q_drained", 32'(exp_ack_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
